// File: rtl/kernel_pr_fifo_pkg.sv
// Shared helpers for the parametrised PageRank stage FIFO: width math,
// the legality check on depth/threshold parameters, and the per-cycle operation type.
package kernel_pr_fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit params_legal(input int depth, input int af_level, input int ae_level);
        return (depth >= 2) && (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level < depth);
    endfunction

endpackage

// File: rtl/kernel_pr_fifo_param_mem.sv
// DEPTH x DATA_WIDTH storage for kernel_pr_fifo_param: one synchronous write
// port and an asynchronous read port for show-ahead output.
module kernel_pr_fifo_param_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kernel_pr_fifo_param.sv
// Parametrised circular-buffer FIFO with occupancy and almost-full/empty flags.
// Optional sticky overflow/underflow outputs when KERNEL_PR_FIFO_ERR_FLAG_EN is defined.
module kernel_pr_fifo_param
    import kernel_pr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap,
`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
    output logic                  if_overflow,
    output logic                  if_underflow,
`endif
    output logic                  if_almost_full,
    output logic                  if_almost_empty
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL) || (count_width(DEPTH) != CW)) begin : g_param_check
        $error("kernel_pr_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL/ADDR_WIDTH combination");
    end

    logic [ADDR_WIDTH-1:0] wptr = '0;
    logic [ADDR_WIDTH-1:0] rptr = '0;
    logic [CW-1:0]         count = '0;
    logic                  empty_n = 1'b0;
    logic                  full_n = 1'b1;
    logic                  almost_full = 1'b0;
    logic                  almost_empty = 1'b1;

    logic                  wr;
    logic                  rd;
    fifo_op_e              op;
    logic [CW-1:0]         next_count;
    logic [ADDR_WIDTH-1:0] wptr_inc;
    logic [ADDR_WIDTH-1:0] rptr_inc;

    assign wr = if_write & if_write_ce & full_n;
    assign rd = if_read & if_read_ce & empty_n;
    assign op = fifo_op_e'({rd, wr});

    always_comb begin
        next_count = count;
        wptr_inc   = (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
        rptr_inc   = (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
        unique case (op)
            OP_WRITE: next_count = count + 1'b1;
            OP_READ:  next_count = count - 1'b1;
            default:  next_count = count;
        endcase
    end

    // Flags are registered from next_count so they change on the same edge as the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            empty_n      <= 1'b0;
            full_n       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr) begin
                wptr <= wptr_inc;
            end
            if (rd) begin
                rptr <= rptr_inc;
            end
            count        <= next_count;
            empty_n      <= (next_count != '0);
            full_n       <= (next_count != CW'(DEPTH));
            almost_full  <= (next_count >= CW'(AF_LEVEL));
            almost_empty <= (next_count <= CW'(AE_LEVEL));
        end
    end

    kernel_pr_fifo_param_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr & ~reset),
        .waddr (wptr),
        .wdata (if_din),
        .raddr (rptr),
        .rdata (if_dout)
    );

`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
    logic overflow = 1'b0;
    logic underflow = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (if_write & if_write_ce & ~full_n) begin
                overflow <= 1'b1;
            end
            if (if_read & if_read_ce & ~empty_n) begin
                underflow <= 1'b1;
            end
        end
    end

    assign if_overflow  = overflow;
    assign if_underflow = underflow;
`endif

    assign if_empty_n        = empty_n;
    assign if_full_n         = full_n;
    assign if_num_data_valid = count;
    assign if_fifo_cap       = CW'(DEPTH);
    assign if_almost_full    = almost_full;
    assign if_almost_empty   = almost_empty;

endmodule

// File: tb/tb_kernel_pr_fifo_param.sv
// Bench for kernel_pr_fifo_param (DEPTH=5, AF=4, AE=1) against a queue-based reference model.
module tb_kernel_pr_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_empty_n;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic [DW-1:0] if_dout;
    logic          if_full_n;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic [AW:0]   if_num_data_valid;
    logic [AW:0]   if_fifo_cap;
    logic          if_almost_full;
    logic          if_almost_empty;
`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
    logic          if_overflow;
    logic          if_underflow;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    bit            ovf_m = 1'b0;
    bit            unf_m = 1'b0;

    always #5 clk = ~clk;

    kernel_pr_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_empty_n        (if_empty_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
        .if_full_n         (if_full_n),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_num_data_valid (if_num_data_valid),
        .if_fifo_cap       (if_fifo_cap),
`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
        .if_overflow       (if_overflow),
        .if_underflow      (if_underflow),
`endif
        .if_almost_full    (if_almost_full),
        .if_almost_empty   (if_almost_empty)
    );

    // Drives one cycle of stimulus and advances the reference model; returns just after the edge.
    task automatic step(input bit rst, input bit w, input bit wce, input bit r, input bit rce,
                        input logic [DW-1:0] d);
        bit acc_w;
        bit acc_r;
        @(negedge clk);
        reset = rst;
        if_write = w;
        if_write_ce = wce;
        if_read = r;
        if_read_ce = rce;
        if_din = d;
        if (rst) begin
            model_q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            acc_w = w && wce && (model_q.size() < DEPTH);
            acc_r = r && rce && (model_q.size() > 0);
            if (w && wce && model_q.size() == DEPTH) ovf_m = 1'b1;
            if (r && rce && model_q.size() == 0) unf_m = 1'b1;
            if (acc_r) void'(model_q.pop_front());
            if (acc_w) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 1, 0, 1, '0);
        step(1, 1, 1, 1, 1, 8'hAA);
        checks++; if (if_num_data_valid !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", if_num_data_valid); end
        checks++; if (if_empty_n !== 1'b0) begin failures++; $display("FAIL reset_empty_n got=%b exp=0", if_empty_n); end
        checks++; if (if_full_n !== 1'b1) begin failures++; $display("FAIL reset_full_n got=%b exp=1", if_full_n); end
        checks++; if (if_almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", if_almost_full); end
        checks++; if (if_almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", if_almost_empty); end
        checks++; if (if_fifo_cap !== 4'd5) begin failures++; $display("FAIL fifo_cap got=%0d exp=5", if_fifo_cap); end
    endtask

    task automatic test_fill();
        int ec;
        step(1, 0, 1, 0, 1, '0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0, 1, (i < 5) ? DW'(8'h11 + i) : 8'h99);
            ec = (i < 5) ? i + 1 : 5;
            checks++; if (if_num_data_valid !== 4'(ec)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, if_num_data_valid, ec); end
            checks++; if (if_almost_empty !== (ec <= AE)) begin failures++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, if_almost_empty, ec <= AE); end
            checks++; if (if_almost_full !== (ec >= AF)) begin failures++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, if_almost_full, ec >= AF); end
            checks++; if (if_full_n !== (ec != DEPTH)) begin failures++; $display("FAIL fill_full_n[%0d] got=%b exp=%b", i, if_full_n, ec != DEPTH); end
            checks++; if (if_empty_n !== 1'b1) begin failures++; $display("FAIL fill_empty_n[%0d] got=%b exp=1", i, if_empty_n); end
        end
    endtask

    task automatic test_drain();
        int ec;
        logic [DW-1:0] e;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                e = DW'(8'h11 + i);
                checks++; if (if_dout !== e) begin failures++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, if_dout, e); end
            end
            step(0, 0, 1, 1, 1, '0);
            ec = (i < 5) ? 4 - i : 0;
            checks++; if (if_num_data_valid !== 4'(ec)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, if_num_data_valid, ec); end
            checks++; if (if_empty_n !== (ec != 0)) begin failures++; $display("FAIL drain_empty_n[%0d] got=%b exp=%b", i, if_empty_n, ec != 0); end
            checks++; if (if_almost_empty !== (ec <= AE)) begin failures++; $display("FAIL drain_ae[%0d] got=%b exp=%b", i, if_almost_empty, ec <= AE); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] nd;
        step(1, 0, 1, 0, 1, '0);
        step(0, 1, 1, 0, 1, 8'h40);
        step(0, 1, 1, 0, 1, 8'h41);
        nd = 8'h42;
        for (int i = 0; i < 12; i++) begin
            checks++; if (if_dout !== model_q[0]) begin failures++; $display("FAIL b2b_dout[%0d] got=%h exp=%h", i, if_dout, model_q[0]); end
            step(0, 1, 1, 1, 1, nd);
            nd++;
            checks++; if (if_num_data_valid !== 4'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, if_num_data_valid); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (if_dout !== DW'(8'h4C + i)) begin failures++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, if_dout, DW'(8'h4C + i)); end
            step(0, 0, 1, 1, 1, '0);
        end
    endtask

    task automatic test_full_rw();
        step(1, 0, 1, 0, 1, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 1, DW'($urandom_range(0, 8'hDF)));
        step(0, 1, 1, 1, 1, 8'hEE);
        checks++; if (if_num_data_valid !== 4'd4) begin failures++; $display("FAIL fullrw_count got=%0d exp=4", if_num_data_valid); end
        checks++; if (if_full_n !== 1'b1) begin failures++; $display("FAIL fullrw_full_n got=%b exp=1", if_full_n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_dout !== model_q[0]) begin failures++; $display("FAIL fullrw_dout[%0d] got=%h exp=%h", i, if_dout, model_q[0]); end
            step(0, 0, 1, 1, 1, '0);
        end
        checks++; if (if_empty_n !== 1'b0) begin failures++; $display("FAIL fullrw_empty_n got=%b exp=0", if_empty_n); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 1, 0, 1, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, DW'(8'h30 + i));
        step(1, 1, 1, 0, 1, 8'h77);
        checks++; if (if_num_data_valid !== 4'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", if_num_data_valid); end
        checks++; if (if_empty_n !== 1'b0) begin failures++; $display("FAIL rstmid_empty_n got=%b exp=0", if_empty_n); end
        checks++; if (if_full_n !== 1'b1) begin failures++; $display("FAIL rstmid_full_n got=%b exp=1", if_full_n); end
        checks++; if (if_almost_empty !== 1'b1) begin failures++; $display("FAIL rstmid_ae got=%b exp=1", if_almost_empty); end
        step(0, 1, 1, 0, 1, 8'h5A);
        checks++; if (if_dout !== 8'h5A) begin failures++; $display("FAIL rstmid_dout got=%h exp=5a", if_dout); end
        checks++; if (if_num_data_valid !== 4'd1) begin failures++; $display("FAIL rstmid_count1 got=%0d exp=1", if_num_data_valid); end
    endtask

    task automatic test_random();
        int n;
        step(1, 0, 1, 0, 1, '0);
        for (int i = 0; i < 400; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), DW'($urandom));
            n = model_q.size();
            checks++; if (if_num_data_valid !== 4'(n)) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, if_num_data_valid, n); end
            checks++; if ({if_empty_n, if_full_n, if_almost_full, if_almost_empty} !== {n != 0, n != DEPTH, n >= AF, n <= AE}) begin
                failures++; $display("FAIL rnd_flags[%0d] got=%b%b%b%b exp=%b%b%b%b", i, if_empty_n, if_full_n, if_almost_full, if_almost_empty, n != 0, n != DEPTH, n >= AF, n <= AE);
            end
            if (n > 0) begin
                checks++; if (if_dout !== model_q[0]) begin failures++; $display("FAIL rnd_dout[%0d] got=%h exp=%h", i, if_dout, model_q[0]); end
            end
`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
            checks++; if ({if_overflow, if_underflow} !== {ovf_m, unf_m}) begin failures++; $display("FAIL rnd_err[%0d] got=%b%b exp=%b%b", i, if_overflow, if_underflow, ovf_m, unf_m); end
`endif
        end
    endtask

`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
    task automatic test_err_flags();
        step(1, 0, 1, 0, 1, '0);
        checks++; if ({if_overflow, if_underflow} !== 2'b00) begin failures++; $display("FAIL err_reset got=%b%b exp=00", if_overflow, if_underflow); end
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 1, DW'(i));
        checks++; if (if_overflow !== 1'b0) begin failures++; $display("FAIL err_ovf_early got=%b exp=0", if_overflow); end
        step(0, 1, 1, 0, 1, 8'hFF);
        checks++; if ({if_overflow, if_underflow} !== 2'b10) begin failures++; $display("FAIL err_ovf got=%b%b exp=10", if_overflow, if_underflow); end
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 1, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, '0);
        checks++; if ({if_overflow, if_underflow} !== 2'b11) begin failures++; $display("FAIL err_both got=%b%b exp=11", if_overflow, if_underflow); end
        step(1, 0, 1, 0, 1, '0);
        checks++; if ({if_overflow, if_underflow} !== 2'b00) begin failures++; $display("FAIL err_clear got=%b%b exp=00", if_overflow, if_underflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_rw();
        test_reset_mid();
`ifdef KERNEL_PR_FIFO_ERR_FLAG_EN
        test_err_flags();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
